rom_read_arbiter: RTL

- Shares the single read port of the boot ROM between two requesters: master 0 is the core instruction-fetch port and master 1 is the core data port.
- Accepts one read at a time and forwards it to the ROM as a single-cycle address beat.
- Routes the ROM response back to the granted master, then releases the port.
- Sits between the core-side bus adapters and the boot ROM inside the SoC memory subsystem.

---
 rtl/rom_read_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
// Two-master arbiter for the boot ROM read port: one read in flight at a time.
// Define ROM_ARB_RR_EN for round-robin arbitration (default: fixed priority, m1 over m0).
module rom_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        win;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        arready_c, rvalid_c;
  logic              s_arvalid_c, s_rready_c;

`ifdef ROM_ARB_RR_EN
  // last_q = 1 when m1 was granted last; a tie goes to the other master
  logic last_q;

  always_comb begin
    win = 2'b00;
    if (m0_arvalid && m1_arvalid) win = last_q ? 2'b01 : 2'b10;
    else if (m1_arvalid)          win = 2'b10;
    else if (m0_arvalid)          win = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             last_q <= 1'b0;
    else if (state_q == IDLE && win != '0)  last_q <= win[1];
  end
`else
  always_comb begin
    win = 2'b00;
    if (m1_arvalid)      win = 2'b10;
    else if (m0_arvalid) win = 2'b01;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Address is pure data; it is only observed while in ADDR
  always_ff @(posedge clk) begin
    if (state_q == IDLE && win != '0) addr_q <= win[1] ? m1_araddr : m0_araddr;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    arready_c   = 2'b00;
    rvalid_c    = 2'b00;
    s_arvalid_c = 1'b0;
    s_rready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win != '0) begin
          arready_c = win;
          gnt_d     = win;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        s_arvalid_c = 1'b1;
        if (s_arready) state_d = RESP;
      end
      RESP: begin
        s_rready_c = gnt_q[1] ? m1_rready : m0_rready;
        rvalid_c   = gnt_q & {2{s_rvalid}};
        if (s_rvalid && s_rready_c) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Outputs are forced low while reset is held, including the pass-through data
  assign m0_arready = rst_n & arready_c[0];
  assign m1_arready = rst_n & arready_c[1];
  assign m0_rvalid  = rst_n & rvalid_c[0];
  assign m1_rvalid  = rst_n & rvalid_c[1];
  assign m0_rdata   = rst_n ? s_rdata : '0;
  assign m1_rdata   = rst_n ? s_rdata : '0;
  assign s_arvalid  = rst_n & s_arvalid_c;
  assign s_araddr   = (rst_n && state_q == ADDR) ? addr_q : '0;
  assign s_rready   = rst_n & s_rready_c;
  assign gnt_o      = rst_n ? gnt_q : 2'b00;

endmodule
